data_cache_controller: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache between the MEM stage and main memory.
- Responder side of the BUSYWAIT handshake that stalls the pipeline registers. It drives BUSYWAIT while a miss is serviced.
- Serves word loads and stores from the CPU. Fills and evicts whole blocks over a separate main-memory handshake.

---
 rtl/cache_pkg.sv | 24 ++
 rtl/cache_line_array.sv | 56 +++++
 rtl/data_cache_controller.sv | 136 +++++++++++++
 tb/tb_data_cache_controller.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache:
// field widths, FSM state encoding and a block word-select helper.
package cache_pkg;

  localparam int LINES   = 8;
  localparam int WORDS   = 4;
  localparam int IW      = 3;
  localparam int OW      = 2;
  localparam int TAG_W   = 32 - IW - OW - 2;
  localparam int BLOCK_W = 32 * WORDS;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    ALLOCATE  = 2'd3
  } cache_state_t;

  function automatic logic [31:0] select_word(input logic [BLOCK_W-1:0] block,
                                              input logic [OW-1:0]      offset);
    return block[{offset, 5'd0} +: 32];
  endfunction

endpackage

// File: rtl/cache_line_array.sv
// Valid/dirty/tag/data storage for the cache: one combinational line read,
// a synchronous word store port and a synchronous whole-block fill port.
module cache_line_array
  import cache_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic [IW-1:0]      rd_index,
  output logic               rd_valid,
  output logic               rd_dirty,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [BLOCK_W-1:0] rd_block,
  input  logic               wr_en,
  input  logic [IW-1:0]      wr_index,
  input  logic [OW-1:0]      wr_offset,
  input  logic [31:0]        wr_word,
  input  logic               fill_en,
  input  logic [IW-1:0]      fill_index,
  input  logic [TAG_W-1:0]   fill_tag,
  input  logic [BLOCK_W-1:0] fill_block
);

  logic [LINES-1:0]   valid_r;
  logic [LINES-1:0]   dirty_r;
  logic [TAG_W-1:0]   tag_r  [LINES];
  logic [BLOCK_W-1:0] data_r [LINES];

  assign rd_valid = valid_r[rd_index];
  assign rd_dirty = dirty_r[rd_index];
  assign rd_tag   = tag_r[rd_index];
  assign rd_block = data_r[rd_index];

  // Line status: a fill leaves the line clean, a store marks it dirty.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      valid_r <= {LINES{1'b0}};
      dirty_r <= {LINES{1'b0}};
    end else if (fill_en) begin
      valid_r[fill_index] <= 1'b1;
      dirty_r[fill_index] <= 1'b0;
    end else if (wr_en) begin
      dirty_r[wr_index] <= 1'b1;
    end
  end

  // Tag and data payload; contents are meaningless until valid_r is set.
  always_ff @(posedge CLK) begin
    if (fill_en) begin
      tag_r[fill_index]  <= fill_tag;
      data_r[fill_index] <= fill_block;
    end else if (wr_en) begin
      data_r[wr_index][{wr_offset, 5'd0} +: 32] <= wr_word;
    end
  end

endmodule

// File: rtl/data_cache_controller.sv
// Direct-mapped, write-back, write-allocate data cache. Stalls the pipeline
// with BUSYWAIT while a miss evicts and refills a block from main memory.
module data_cache_controller
  import cache_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               READ,
  input  logic               WRITE,
  input  logic [31:0]        ADDRESS,
  input  logic [31:0]        WRITEDATA,
  output logic [31:0]        READDATA,
  output logic               BUSYWAIT,
  output logic               MEM_READ,
  output logic               MEM_WRITE,
  output logic [27:0]        MEM_ADDRESS,
  output logic [BLOCK_W-1:0] MEM_WRITEDATA,
  input  logic [BLOCK_W-1:0] MEM_READDATA,
  input  logic               MEM_BUSYWAIT
);

  cache_state_t       state_r;
  logic [TAG_W-1:0]   miss_tag_r;
  logic [IW-1:0]      miss_index_r;
  logic [31:0]        readdata_r;

  logic [TAG_W-1:0]   req_tag_s;
  logic [IW-1:0]      req_index_s;
  logic [OW-1:0]      req_offset_s;
  logic               addr_unused_s;
  logic [IW-1:0]      line_index_s;
  logic               line_valid_s;
  logic               line_dirty_s;
  logic [TAG_W-1:0]   line_tag_s;
  logic [BLOCK_W-1:0] line_block_s;
  logic               idle_s;
  logic               hit_s;
  logic               miss_s;
  logic               read_hit_s;
  logic               write_hit_s;
  logic [31:0]        hit_word_s;

  assign req_tag_s     = ADDRESS[31:7];
  assign req_index_s   = ADDRESS[6:4];
  assign req_offset_s  = ADDRESS[3:2];
  assign addr_unused_s = ^ADDRESS[1:0];

  // Outside IDLE the array looks at the latched miss line (victim, then fill target).
  assign idle_s       = (state_r == IDLE);
  assign line_index_s = idle_s ? req_index_s : miss_index_r;

  cache_line_array u_lines (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .rd_index   (line_index_s),
    .rd_valid   (line_valid_s),
    .rd_dirty   (line_dirty_s),
    .rd_tag     (line_tag_s),
    .rd_block   (line_block_s),
    .wr_en      (write_hit_s),
    .wr_index   (req_index_s),
    .wr_offset  (req_offset_s),
    .wr_word    (WRITEDATA),
    .fill_en    (state_r == ALLOCATE),
    .fill_index (miss_index_r),
    .fill_tag   (miss_tag_r),
    .fill_block (MEM_READDATA)
  );

  assign hit_s       = line_valid_s && (line_tag_s == req_tag_s);
  assign miss_s      = idle_s && (READ || WRITE) && !hit_s;
  assign read_hit_s  = idle_s && READ && !WRITE && hit_s;
  assign write_hit_s = idle_s && WRITE && hit_s;
  assign hit_word_s  = select_word(line_block_s, req_offset_s);

  assign READDATA = read_hit_s ? hit_word_s : readdata_r;
  assign BUSYWAIT = RESET_N && (!idle_s || miss_s);

  // Memory-side request decode from the current state.
  always_comb begin
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = 28'h0;
    MEM_WRITEDATA = {BLOCK_W{1'b0}};
    case (state_r)
      WRITEBACK: begin
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {line_tag_s, miss_index_r};
        MEM_WRITEDATA = line_block_s;
      end
      FETCH: begin
        MEM_READ    = 1'b1;
        MEM_ADDRESS = {miss_tag_r, miss_index_r};
      end
      default: begin
        MEM_READ = 1'b0;
      end
    endcase
  end

  // Miss sequencing plus the register that holds the last load result.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r      <= IDLE;
      miss_tag_r   <= {TAG_W{1'b0}};
      miss_index_r <= {IW{1'b0}};
      readdata_r   <= 32'h0;
    end else begin
      if (read_hit_s) begin
        readdata_r <= hit_word_s;
      end
      case (state_r)
        IDLE: begin
          if (miss_s) begin
            miss_tag_r   <= req_tag_s;
            miss_index_r <= req_index_s;
            state_r      <= (line_valid_s && line_dirty_s) ? WRITEBACK : FETCH;
          end
        end
        WRITEBACK: begin
          if (!MEM_BUSYWAIT) state_r <= FETCH;
        end
        FETCH: begin
          if (!MEM_BUSYWAIT) state_r <= ALLOCATE;
        end
        ALLOCATE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_cache_controller.sv
// Scoreboard bench: a word-level memory model predicts load data, stall length
// and memory traffic per request; a negedge monitor compares completions.
module tb_data_cache_controller;
  import cache_pkg::*;

  logic               CLK = 1'b0;
  logic               RESET_N;
  logic               READ, WRITE;
  logic [31:0]        ADDRESS, WRITEDATA, READDATA;
  logic               BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
  logic [27:0]        MEM_ADDRESS;
  logic [BLOCK_W-1:0] MEM_WRITEDATA, MEM_READDATA;

  int checks = 0;
  int errors = 0;

  data_cache_controller dut (
    .CLK(CLK), .RESET_N(RESET_N), .READ(READ), .WRITE(WRITE),
    .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA),
    .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [BLOCK_W-1:0] act,
                       input logic [BLOCK_W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [BLOCK_W-1:0] init_blk(input int a);
    logic [BLOCK_W-1:0] b;
    if (a == 4) return {32'h33, 32'h22, 32'h11, 32'h00};
    for (int k = 0; k < 4; k++) b[k*32 +: 32] = 32'hA500_0000 | (a << 8) | k;
    return b;
  endfunction

  // Main memory: a read occupies N cycles, a write-back N+1 (write commit).
  int                 mem_lat_n = 5;
  int                 mem_cnt = 0;
  bit                 mem_written [64];
  logic [BLOCK_W-1:0] mem_wdata [64];
  logic [BLOCK_W-1:0] mem_rdata;

  assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) &&
                        (mem_cnt < (MEM_WRITE ? mem_lat_n : mem_lat_n - 1));
  assign MEM_READDATA = mem_rdata;

  always @(posedge CLK) begin
    if ((MEM_READ || MEM_WRITE) && MEM_BUSYWAIT) mem_cnt <= mem_cnt + 1;
    else mem_cnt <= 0;
    if (MEM_READ)
      mem_rdata <= mem_written[MEM_ADDRESS[5:0]] ? mem_wdata[MEM_ADDRESS[5:0]]
                                                 : init_blk(int'(MEM_ADDRESS[5:0]));
    if (MEM_WRITE && !MEM_BUSYWAIT) begin
      mem_written[MEM_ADDRESS[5:0]] <= 1'b1;
      mem_wdata[MEM_ADDRESS[5:0]]   <= MEM_WRITEDATA;
    end
  end

  typedef struct {
    logic [31:0]        rdata;
    int                 stall;
    bit                 has_wb;
    logic [27:0]        wb_addr;
    logic [BLOCK_W-1:0] wb_data;
    bit                 has_fetch;
    logic [27:0]        fetch_addr;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: CPU-visible block contents, main-memory contents, and
  // which block each cache line holds (to predict evictions and latency).
  logic [BLOCK_W-1:0] cpu_blk [64];
  logic [BLOCK_W-1:0] model_mem [64];
  bit                 m_valid [8];
  bit                 m_dirty [8];
  int                 m_tag [8];
  logic [31:0]        last_rd;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      if (m_valid[i] && m_dirty[i]) cpu_blk[m_tag[i]*8 + i] = model_mem[m_tag[i]*8 + i];
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    last_rd = 32'h0;
  endtask

  task automatic do_req(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input int n);
    exp_t e;
    int blk, idx, tg, off, vblk, k;
    bit hit;
    blk = int'(addr[9:4]);
    idx = int'(addr[6:4]);
    tg  = int'(addr[9:7]);
    off = int'(addr[3:2]);
    hit = m_valid[idx] && (m_tag[idx] == tg);
    e.has_wb = 1'b0; e.wb_addr = 28'h0; e.wb_data = {BLOCK_W{1'b0}};
    e.has_fetch = 1'b0; e.fetch_addr = 28'h0; e.stall = 0;
    if (!hit) begin
      e.has_fetch  = 1'b1;
      e.fetch_addr = 28'(blk);
      if (m_valid[idx] && m_dirty[idx]) begin
        vblk = m_tag[idx]*8 + idx;
        e.has_wb  = 1'b1;
        e.wb_addr = 28'(vblk);
        e.wb_data = cpu_blk[vblk];
        model_mem[vblk] = cpu_blk[vblk];
        e.stall = 2*n + 3;
      end else begin
        e.stall = n + 2;
      end
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_dirty[idx] = 1'b0;
    end
    if (wr) begin
      cpu_blk[blk][off*32 +: 32] = data;
      m_dirty[idx] = 1'b1;
      e.rdata = last_rd;
    end else begin
      e.rdata = cpu_blk[blk][off*32 +: 32];
      last_rd = e.rdata;
    end
    exp_q.push_back(e);
    mem_lat_n = n;
    READ = rd; WRITE = wr; ADDRESS = addr; WRITEDATA = data;
    for (k = 0; k < 200; k++) begin
      @(negedge CLK);
      if (!BUSYWAIT) break;
    end
    if (k == 200) check("req_timeout", 128'(addr), 128'hFFFF);
    @(posedge CLK); #1;
    READ = 1'b0; WRITE = 1'b0;
  endtask

  // Monitor: tracks stall length and memory traffic, pops on completion.
  int                 stall_cnt;
  bit                 saw_wb, saw_fetch, wb_first;
  logic [27:0]        cap_wb_addr, cap_fetch_addr;
  logic [BLOCK_W-1:0] cap_wb_data;
  exp_t               mon_e;

  initial begin
    stall_cnt = 0; saw_wb = 1'b0; saw_fetch = 1'b0; wb_first = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RESET_N) begin
        stall_cnt = 0; saw_wb = 1'b0; saw_fetch = 1'b0; wb_first = 1'b0;
      end else begin
        if (MEM_WRITE && !saw_wb) begin
          saw_wb = 1'b1; cap_wb_addr = MEM_ADDRESS; cap_wb_data = MEM_WRITEDATA;
        end
        if (MEM_READ && !saw_fetch) begin
          saw_fetch = 1'b1; cap_fetch_addr = MEM_ADDRESS; wb_first = saw_wb;
        end
        if (READ || WRITE) begin
          if (BUSYWAIT) begin
            stall_cnt++;
          end else if (exp_q.size() == 0) begin
            check("unexpected_completion", 128'(ADDRESS), 128'hFFFF_FFFF_F);
          end else begin
            mon_e = exp_q.pop_front();
            check("stall_cycles", 128'(stall_cnt), 128'(mon_e.stall));
            check("readdata", 128'(READDATA), 128'(mon_e.rdata));
            check("writeback_seen", 128'(saw_wb), 128'(mon_e.has_wb));
            check("fetch_seen", 128'(saw_fetch), 128'(mon_e.has_fetch));
            if (mon_e.has_wb && saw_wb) begin
              check("wb_address", 128'(cap_wb_addr), 128'(mon_e.wb_addr));
              check("wb_data", cap_wb_data, mon_e.wb_data);
              check("wb_before_fetch", 128'(wb_first), 128'(1));
            end
            if (mon_e.has_fetch && saw_fetch)
              check("fetch_address", 128'(cap_fetch_addr), 128'(mon_e.fetch_addr));
            stall_cnt = 0; saw_wb = 1'b0; saw_fetch = 1'b0; wb_first = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int r;
    RESET_N = 1'b0; READ = 1'b0; WRITE = 1'b0; ADDRESS = 32'h0; WRITEDATA = 32'h0;
    for (int a = 0; a < 64; a++) begin
      cpu_blk[a]   = init_blk(a);
      model_mem[a] = init_blk(a);
    end
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = 0;
    end
    last_rd = 32'h0;
    #1;
    check("rst_readdata", 128'(READDATA), 128'(0));
    check("rst_busywait", 128'(BUSYWAIT), 128'(0));
    check("rst_mem_read", 128'(MEM_READ), 128'(0));
    check("rst_mem_write", 128'(MEM_WRITE), 128'(0));
    check("rst_mem_address", 128'(MEM_ADDRESS), 128'(0));
    check("rst_mem_writedata", MEM_WRITEDATA, 128'(0));
    repeat (3) @(posedge CLK);
    @(negedge CLK); RESET_N = 1'b1;
    @(posedge CLK); #1;

    do_req(1'b1, 1'b0, 32'h0000_0040, 32'h0, 5);          // clean miss, N=5
    do_req(1'b1, 1'b0, 32'h0000_0048, 32'h0, 5);          // hit, same-cycle data
    do_req(1'b0, 1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 5);  // write hit
    do_req(1'b1, 1'b0, 32'h0000_0044, 32'h0, 5);
    do_req(1'b1, 1'b0, 32'h0000_00C0, 32'h0, 5);          // dirty eviction
    do_req(1'b1, 1'b1, 32'h0000_0250, 32'h1234_5678, 5);  // both -> store
    do_req(1'b1, 1'b0, 32'h0000_0250, 32'h0, 5);
    do_req(1'b1, 1'b0, 32'h0000_0048, 32'h0, 5);

    // Reset while a fetch is outstanding.
    mem_lat_n = 5;
    READ = 1'b1; WRITE = 1'b0; ADDRESS = 32'h0000_01A0;
    for (k = 0; k < 50; k++) begin
      @(negedge CLK);
      if (MEM_READ) break;
    end
    if (k == 50) check("fetch_never_started", 128'(MEM_READ), 128'(1));
    #2 RESET_N = 1'b0;
    #1;
    check("midmiss_rst_mem_read", 128'(MEM_READ), 128'(0));
    check("midmiss_rst_busywait", 128'(BUSYWAIT), 128'(0));
    check("midmiss_rst_readdata", 128'(READDATA), 128'(0));
    READ = 1'b0;
    exp_q.delete();
    model_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK); RESET_N = 1'b1;
    @(posedge CLK); #1;
    do_req(1'b1, 1'b0, 32'h0000_0048, 32'h0, 5);          // now a miss again
    do_req(1'b1, 1'b0, 32'h0000_0250, 32'h0, 3);          // dirty store was lost

    for (int t = 0; t < 200; t++) begin
      r = $urandom_range(0, 9);
      do_req(r < 5 || r == 9, r >= 5,
             32'(($urandom_range(0, 63) << 4) | ($urandom_range(0, 3) << 2)),
             $urandom, $urandom_range(1, 4));
      k = $urandom_range(0, 2);
      repeat (k) begin @(posedge CLK); #1; end
    end

    check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
